// File: rtl/vfifo_packet_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vfifo_pkg (package)
//  Purpose  : Shared definitions for the virtual-FIFO packed-stream blocks
//             (packet arbiter, stream expander and its packing counterpart):
//             header field offsets, packet-parser state encoding and a
//             header field extractor.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package vfifo_pkg;

  // Header beat layout (low 32 bits of the header beat)
  localparam int TID_LSB      = 0;
  localparam int TDEST_LSB    = 8;
  localparam int BEAT_CNT_LSB = 16;
  localparam int BEAT_CNT_W   = 8;
  localparam int KEEP_CNT_LSB = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } state_t;

  // Number of data beats following the header, minus one
  function automatic logic [BEAT_CNT_W-1:0] hdr_beat_cnt(input logic [31:0] hdr);
    return hdr[BEAT_CNT_LSB +: BEAT_CNT_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/vfifo_packet_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : vfifo_packet_arbiter_if
//  Purpose  : Bundles the NUM_PORTS source streams and the merged
//             initiator stream of the virtual-FIFO packet arbiter.
//  Modports : master - the arbiter (consumes target_*, drives initiator_*)
//             slave  - the environment (drives target_*, consumes initiator_*)
//  Revision : 1.0 - initial release
// ============================================================================
interface vfifo_packet_arbiter_if #(
  parameter int NUM_PORTS   = 4,
  parameter int TDATA_BYTES = 8
);

  logic [NUM_PORTS-1:0]               target_tvalid;
  logic [NUM_PORTS-1:0]               target_tready;
  logic [NUM_PORTS*8*TDATA_BYTES-1:0] target_tdata;
  logic                               initiator_tvalid;
  logic                               initiator_tready;
  logic [8*TDATA_BYTES-1:0]           initiator_tdata;
  logic                               initiator_tlast;

  modport master (
    input  target_tvalid, target_tdata, initiator_tready,
    output target_tready, initiator_tvalid, initiator_tdata, initiator_tlast
  );

  modport slave (
    output target_tvalid, target_tdata, initiator_tready,
    input  target_tready, initiator_tvalid, initiator_tdata, initiator_tlast
  );

endinterface
`default_nettype wire

// File: rtl/vfifo_packet_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin next-index finder. Searches req
//             starting at last+1, wrapping NUM_PORTS-1 -> 0; last itself
//             has the lowest priority so a lone requester is re-found.
//  Ports    : req  in  NUM_PORTS  request vector
//             last in  IDX_W      previously granted index
//             hit  out 1          at least one request present
//             idx  out IDX_W      winning index (== last when no hit)
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter  int NUM_PORTS = 4,
  localparam int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last,
  output logic                 hit,
  output logic [IDX_W-1:0]     idx
);

  int j;

  // Walk from the farthest offset to the nearest so the nearest hit wins.
  always_comb begin
    hit = 1'b0;
    idx = last;
    j   = 0;
    for (int off = NUM_PORTS; off >= 1; off--) begin
      j = int'(last) + off;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (req[j[IDX_W-1:0]]) begin
        hit = 1'b1;
        idx = j[IDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vfifo_packet_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vfifo_packet_arbiter
//  Purpose  : Packet-granular round-robin arbiter sharing the virtual-FIFO
//             write channel between NUM_PORTS packed-stream sources. The
//             granted port's header gives the packet length (beat_cnt+1
//             data beats); the grant is held for the whole packet.
//  Ports    : aclk       in   clock
//             areset     in   asynchronous active-high reset
//             bus        if   master modport (target_* in, initiator_* out)
//             grant_idx  out  currently / last granted port
//             busy       out  packet in flight (HEADER or DATA)
//             pkt_count  out  per-port 32-bit packet counters
//                             (only when VFIFO_ARB_STATS_EN is defined)
//  Options  : VFIFO_ARB_STATS_EN - adds pkt_count
//  Revision : 1.0 - initial release
// ============================================================================
module vfifo_packet_arbiter
  import vfifo_pkg::*;
#(
  parameter  int NUM_PORTS   = 4,
  parameter  int TDATA_BYTES = 8,
  parameter  int TID_WIDTH   = 4,
  parameter  int TDEST_WIDTH = 1,
  localparam int IDX_W       = $clog2(NUM_PORTS),
  localparam int DW          = 8 * TDATA_BYTES
) (
  input  logic                     aclk,
  input  logic                     areset,
  vfifo_packet_arbiter_if.master   bus,
  output logic [IDX_W-1:0]         grant_idx,
  output logic                     busy
`ifdef VFIFO_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0]  pkt_count
`endif
);

  // Header fields must fit below the beat-count field of a 32-bit header.
  if (TDATA_BYTES < 4 || NUM_PORTS < 2 || NUM_PORTS > 16 ||
      TID_WIDTH > (TDEST_LSB - TID_LSB) ||
      TDEST_WIDTH > (BEAT_CNT_LSB - TDEST_LSB)) begin : g_cfg_err
    $error("vfifo_packet_arbiter: unsupported parameter combination");
  end

  state_t                state, state_nxt;
  logic [BEAT_CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0]      grant_nxt;
  logic                  slot_free;
  logic                  sel_valid;
  logic [DW-1:0]         sel_data;
  logic                  accept;
  logic                  last_beat;
  logic                  arb_hit;
  logic [IDX_W-1:0]      arb_idx;

  // The output register can take a beat when empty or being drained.
  assign slot_free = bus.initiator_tready || !bus.initiator_tvalid;
  assign sel_valid = bus.target_tvalid[grant_idx];
  assign sel_data  = bus.target_tdata[grant_idx*DW +: DW];
  assign accept    = slot_free && (state != IDLE) && sel_valid;
  assign last_beat = (state == DATA) && (cnt == '0);
  assign busy      = (state != IDLE);

  always_comb begin
    bus.target_tready = '0;
    if (slot_free && (state != IDLE)) bus.target_tready[grant_idx] = 1'b1;
  end

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .req  (bus.target_tvalid),
    .last (grant_idx),
    .hit  (arb_hit),
    .idx  (arb_idx)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    grant_nxt = grant_idx;
    case (state)
      IDLE: begin
        if (arb_hit) begin
          grant_nxt = arb_idx;
          state_nxt = HEADER;
        end
      end
      HEADER: begin
        if (accept) begin
          cnt_nxt   = hdr_beat_cnt(sel_data[31:0]);
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          if (cnt == '0) state_nxt = IDLE;
          else           cnt_nxt   = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= IDLE;
      cnt       <= '0;
      grant_idx <= IDX_W'(NUM_PORTS - 1);
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      grant_idx <= grant_nxt;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      bus.initiator_tvalid <= 1'b0;
      bus.initiator_tlast  <= 1'b0;
      bus.initiator_tdata  <= '0;
    end else if (accept) begin
      bus.initiator_tvalid <= 1'b1;
      bus.initiator_tlast  <= last_beat;
      bus.initiator_tdata  <= sel_data;
    end else if (bus.initiator_tready) begin
      // Beat consumed with nothing new behind it; data is left as-is.
      bus.initiator_tvalid <= 1'b0;
      bus.initiator_tlast  <= 1'b0;
    end
  end

`ifdef VFIFO_ARB_STATS_EN
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_stats
    logic [31:0] count;
    always_ff @(posedge aclk or posedge areset) begin
      if (areset)
        count <= '0;
      else if (accept && last_beat && (grant_idx == IDX_W'(p)))
        count <= count + 32'd1;
    end
    assign pkt_count[p*32 +: 32] = count;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vfifo_packet_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vfifo_packet_arbiter
//  Purpose  : Self-checking bench for vfifo_packet_arbiter. Directed packets
//             are queued per source; their expected merged-stream beats go
//             into a scoreboard that a monitor drains on each output
//             handshake. Build with VFIFO_ARB_STATS_EN to cover pkt_count.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vfifo_packet_arbiter;

  localparam int NP = 4;
  localparam int TB = 8;
  localparam int DW = 8 * TB;

  logic       aclk   = 1'b0;
  logic       areset = 1'b1;
  logic [1:0] grant_idx;
  logic       busy;
`ifdef VFIFO_ARB_STATS_EN
  logic [NP*32-1:0] pkt_count;
`endif

  vfifo_packet_arbiter_if #(.NUM_PORTS(NP), .TDATA_BYTES(TB)) bus ();

  vfifo_packet_arbiter #(
    .NUM_PORTS(NP), .TDATA_BYTES(TB), .TID_WIDTH(4), .TDEST_WIDTH(1)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .bus       (bus),
    .grant_idx (grant_idx),
    .busy      (busy)
`ifdef VFIFO_ARB_STATS_EN
    ,
    .pkt_count (pkt_count)
`endif
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [DW-1:0] data; int gap; } src_beat_t;
  typedef struct { logic [DW-1:0] data; logic last; int gap; } exp_beat_t;

  src_beat_t srcq [NP][$];
  exp_beat_t expq [$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_hs_cyc = 0;
  int hs_count    = 0;
  int pkt_id      = 0;
  bit sb_off      = 1'b0;
  bit toggle      = 1'b0;
  logic [NP-1:0] take = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit src_pending();
    for (int p = 0; p < NP; p++) if (srcq[p].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // One header (beat_cnt = bc) plus bc+1 data beats. hdr_gap: required
  // cycles between the previous output beat and this header (-1 = any).
  // full_rate: data beats must follow one per cycle. Data beat stall_beat
  // is withheld by the source for stall_len cycles.
  task automatic send_pkt(input int p, input int bc, input int hdr_gap,
                          input bit full_rate, input int stall_beat, input int stall_len);
    logic [DW-1:0] d;
    src_beat_t     s;
    exp_beat_t     e;
    pkt_id++;
    d        = '0;
    d[63:56] = 8'hA5;
    d[55:48] = 8'(p);
    d[47:40] = 8'(pkt_id);
    d[23:16] = 8'(bc);
    d[8]     = p[0];
    d[3:0]   = 4'(pkt_id);
    s.data = d; s.gap = 0;
    srcq[p].push_back(s);
    e.data = d; e.last = 1'b0; e.gap = hdr_gap;
    expq.push_back(e);
    for (int b = 0; b <= bc; b++) begin
      d = {8'hDA, 8'(p), 8'(pkt_id), 8'h00, 32'(b)};
      s.data = d; s.gap = (b == stall_beat) ? stall_len : 0;
      srcq[p].push_back(s);
      e.data = d; e.last = (b == bc);
      e.gap  = (full_rate && b != stall_beat) ? 1 : -1;
      expq.push_back(e);
    end
  endtask

  task automatic drain(input string name, input int max);
    int n = 0;
    while ((expq.size() != 0 || src_pending()) && n < max) begin
      @(negedge aclk);
      n++;
    end
    if (n >= max) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_drain: got %0d beats outstanding, expected 0", name, expq.size());
    end
    repeat (3) @(negedge aclk);
  endtask

  task automatic wait_hs(input string name, input int target, input int max);
    int n = 0;
    while (hs_count < target && n < max) begin
      @(negedge aclk);
      n++;
    end
    if (n >= max) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_wait: got %0d handshakes, expected %0d", name, hs_count, target);
    end
  endtask

  task automatic flush_sources();
    for (int p = 0; p < NP; p++) srcq[p].delete();
  endtask

  task automatic reset_pulse();
    @(posedge aclk); #1;
    areset = 1'b1;
    flush_sources();
    @(posedge aclk); #1;
    areset = 1'b0;
  endtask

  // Source side: sample handshakes away from the edge, update after it.
  always @(negedge aclk) take = bus.target_tvalid & bus.target_tready;

  initial begin
    src_beat_t h;
    bus.target_tvalid    = '0;
    bus.target_tdata     = '0;
    bus.initiator_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (take[p] && srcq[p].size() > 0) void'(srcq[p].pop_front());
        if (srcq[p].size() > 0 && srcq[p][0].gap > 0) begin
          bus.target_tvalid[p] = 1'b0;
          h = srcq[p][0];
          h.gap--;
          srcq[p][0] = h;
        end else if (srcq[p].size() > 0) begin
          bus.target_tvalid[p]          = 1'b1;
          bus.target_tdata[p*DW +: DW]  = srcq[p][0].data;
        end else begin
          bus.target_tvalid[p] = 1'b0;
        end
      end
      if (toggle) bus.initiator_tready = ~bus.initiator_tready;
      else        bus.initiator_tready = 1'b1;
    end
  end

  // Monitor: scoreboard pop on every output handshake, plus hold checks.
  exp_beat_t     mon_e;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  bit            stall_prev = 1'b0;

  always @(negedge aclk) begin
    cyc++;
    if (areset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        vectors++;
        if (!(bus.initiator_tvalid && bus.initiator_tdata == prev_data &&
              bus.initiator_tlast == prev_last)) begin
          miscompares++;
          $display("FAIL stall_hold: got v=%0b d=%0h l=%0b, expected v=1 d=%0h l=%0b",
                   bus.initiator_tvalid, bus.initiator_tdata, bus.initiator_tlast,
                   prev_data, prev_last);
        end
      end
      stall_prev = bus.initiator_tvalid && !bus.initiator_tready;
      prev_data  = bus.initiator_tdata;
      prev_last  = bus.initiator_tlast;
      if (bus.initiator_tvalid && bus.initiator_tready) begin
        hs_count++;
        if (!sb_off) begin
          vectors++;
          if (expq.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_beat: got d=%0h, expected no beat", bus.initiator_tdata);
          end else begin
            mon_e = expq.pop_front();
            if (bus.initiator_tdata != mon_e.data || bus.initiator_tlast != mon_e.last ||
                (mon_e.gap >= 0 && (cyc - last_hs_cyc) != mon_e.gap)) begin
              miscompares++;
              $display("FAIL out_beat: got d=%0h l=%0b gap=%0d, expected d=%0h l=%0b gap=%0d",
                       bus.initiator_tdata, bus.initiator_tlast, cyc - last_hs_cyc,
                       mon_e.data, mon_e.last, mon_e.gap);
            end
          end
        end
        last_hs_cyc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    // Reset values
    @(negedge aclk);
    check("rst_tvalid", bus.initiator_tvalid, 1'b0);
    check("rst_tlast",  bus.initiator_tlast,  1'b0);
    check("rst_tdata",  bus.initiator_tdata,  64'h0);
    check("rst_tready", bus.target_tready,    4'h0);
    check("rst_grant",  grant_idx,            2'd3);
    check("rst_busy",   busy,                 1'b0);
    @(posedge aclk); #1;
    areset = 1'b0;

    // Single port 0, beat_cnt=3: 5 beats, tlast on the 5th
    hs0 = hs_count;
    send_pkt(0, 3, -1, 1'b1, -1, 0);
    wait_hs("t1", hs0 + 2, 50);
    check("t1_busy_mid",  busy,      1'b1);
    check("t1_grant_mid", grant_idx, 2'd0);
    drain("t1", 100);
    check("t1_grant", grant_idx, 2'd0);
    check("t1_busy",  busy,      1'b0);

    // Ports 0,1,2 all requesting, beat_cnt=0: order 0,1,2,0,1,2, one bubble
    reset_pulse();
    send_pkt(0, 0, -1, 1'b1, -1, 0);
    send_pkt(1, 0,  2, 1'b1, -1, 0);
    send_pkt(2, 0,  2, 1'b1, -1, 0);
    send_pkt(0, 0,  2, 1'b1, -1, 0);
    send_pkt(1, 0,  2, 1'b1, -1, 0);
    send_pkt(2, 0,  2, 1'b1, -1, 0);
    drain("t2", 200);
    check("t2_grant", grant_idx, 2'd2);

    // Port 1, beat_cnt=255 under toggling backpressure: 257 beats
    toggle = 1'b1;
    send_pkt(1, 255, -1, 1'b0, -1, 0);
    drain("t3", 2000);
    toggle = 1'b0;
    check("t3_grant", grant_idx, 2'd1);

    // Port 2 stalls mid-packet for 10 cycles while port 3 waits
    hs0 = hs_count;
    send_pkt(2, 4, -1, 1'b0, 1, 10);
    send_pkt(3, 1, -1, 1'b0, -1, 0);
    wait_hs("t4", hs0 + 2, 50);
    repeat (3) @(negedge aclk);
    check("t4_grant_mid", grant_idx,           2'd2);
    check("t4_busy_mid",  busy,                1'b1);
    check("t4_p3_ready",  bus.target_tready[3], 1'b0);
    drain("t4", 200);
    check("t4_grant", grant_idx, 2'd3);

    // Reset in the DATA phase of a 6-beat packet on port 0
    sb_off = 1'b1;
    hs0 = hs_count;
    send_pkt(0, 4, -1, 1'b0, -1, 0);
    wait_hs("t5", hs0 + 3, 50);
    @(posedge aclk); #1;
    areset = 1'b1;
    flush_sources();
    expq.delete();
    @(negedge aclk);
    check("t5_tvalid", bus.initiator_tvalid, 1'b0);
    check("t5_tlast",  bus.initiator_tlast,  1'b0);
    check("t5_busy",   busy,                 1'b0);
    check("t5_grant",  grant_idx,            2'd3);
    check("t5_tready", bus.target_tready,    4'h0);
    @(posedge aclk); #1;
    areset = 1'b0;
    sb_off = 1'b0;
    send_pkt(0, 1, -1, 1'b1, -1, 0);
    drain("t5", 100);
    check("t5_grant_after", grant_idx, 2'd0);

    // Three packets on port 0, then two on port 3
    reset_pulse();
`ifdef VFIFO_ARB_STATS_EN
    check("t6_cnt_rst", pkt_count, 128'h0);
`endif
    send_pkt(0, 2, -1, 1'b1, -1, 0);
    send_pkt(0, 0, -1, 1'b1, -1, 0);
    send_pkt(0, 1, -1, 1'b1, -1, 0);
    drain("t6a", 200);
`ifdef VFIFO_ARB_STATS_EN
    check("t6_cnt_a", pkt_count, {32'd0, 32'd0, 32'd0, 32'd3});
`endif
    send_pkt(3, 1, -1, 1'b1, -1, 0);
    send_pkt(3, 3, -1, 1'b1, -1, 0);
    drain("t6b", 200);
`ifdef VFIFO_ARB_STATS_EN
    check("t6_cnt_b", pkt_count, {32'd2, 32'd0, 32'd0, 32'd3});
`endif
    check("t6_grant", grant_idx, 2'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
